// File: rtl/burst_cas.sv
// burst_cas: column-command timing stage for the DDR4 controller.
// Holds one request from the activate/precharge sequencer. It waits out tRCD
// (after an ACT) or tCCD (after the previous CAS), then pulses the RD/WR
// command. It frames the data burst window after CL/CWL and reports idle back
// to the sequencer. All outputs come straight from flops.

module burst_cas #(
    parameter int tRCD         = 14,
    parameter int tCCD         = 4,
    parameter int CL           = 14,
    parameter int CWL          = 10,
    parameter int BURST_CYCLES = 4,
    parameter int CA_WIDTH     = 10,
    parameter int BG_WIDTH     = 2,
    parameter int BA_WIDTH     = 2
) (
    input  logic                                   clock_t,
    input  logic                                   reset_n,
    input  logic                                   act_rdy,
    input  logic                                   no_act_rdy,
    input  logic                                   act_rw,
    input  logic [BG_WIDTH-1:0]                    bg_addr,
    input  logic [BA_WIDTH-1:0]                    ba_addr,
    input  logic [CA_WIDTH-1:0]                    col_addr,
    output logic                                   cas_rdy,
    output logic                                   cas_rw,
    output logic [BG_WIDTH+BA_WIDTH+CA_WIDTH-1:0]  cas_reg,
    output logic                                   data_valid,
    output logic                                   data_rw,
    output logic                                   cas_idle,
    output logic                                   proto_err
);

    localparam int ADDR_W = BG_WIDTH + BA_WIDTH + CA_WIDTH;

    // The shared delay counter must reach the longest wait of any state
    // without wrapping. A TCCD wait can last up to tCCD cycles.
    localparam int MAX_A = (tRCD > CL) ? tRCD : CL;
    localparam int MAX_B = (CWL > BURST_CYCLES) ? CWL : BURST_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_T = (MAX_C > tCCD) ? MAX_C : tCCD;
    localparam int CNT_W = $clog2(MAX_T + 1);
    localparam int CCD_W = $clog2(tCCD + 1);

    // The counter holds "cycles elapsed in this phase", starting at 1 on the
    // first cycle of the phase.
    localparam logic [CNT_W-1:0] TRCD_END  = CNT_W'(tRCD - 1);
    localparam logic [CNT_W-1:0] CL_END    = CNT_W'(CL - 1);
    localparam logic [CNT_W-1:0] CWL_END   = CNT_W'(CWL - 1);
    localparam logic [CNT_W-1:0] BURST_END = CNT_W'(BURST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CCD_W-1:0] CCD_MIN   = CCD_W'(tCCD - 1);
    localparam logic [CCD_W-1:0] CCD_SAT   = CCD_W'(tCCD);
    localparam logic [CCD_W-1:0] CCD_ONE   = CCD_W'(1);

    typedef enum logic [2:0] {
        CAS_IDLE,
        CAS_TRCD,
        CAS_TCCD,
        CAS_CMD,
        CAS_LAT,
        CAS_BURST
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    cnt;
    logic [CCD_W-1:0]    ccd_cnt;
    logic                req_rw;
    logic [ADDR_W-1:0]   req_addr;
    logic                accept;
    logic                lat_done;

    logic                cas_rdy_d;
    logic                data_valid_d;
    logic                data_rw_d;
    logic                cas_idle_d;
    logic                load_cas;

    assign accept   = (state == CAS_IDLE) && (act_rdy || no_act_rdy);
    assign lat_done = (cnt == (req_rw ? CWL_END : CL_END));

    // State register.
    // NOTE: every flop in this file uses <= so that all of them update together at the edge.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state <= CAS_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. act_rdy has priority when both request pulses arrive.
    // NOTE: assigning a default first keeps this comb block from inferring a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            CAS_IDLE: begin
                if (act_rdy) begin
                    next_state = CAS_TRCD;
                end else if (no_act_rdy) begin
                    next_state = CAS_TCCD;
                end
            end
            CAS_TRCD:  if (cnt == TRCD_END)    next_state = CAS_CMD;
            CAS_TCCD:  if (ccd_cnt >= CCD_MIN) next_state = CAS_CMD;
            CAS_CMD:   next_state = CAS_LAT;
            CAS_LAT:   if (lat_done)           next_state = CAS_BURST;
            CAS_BURST: if (cnt == BURST_END)   next_state = CAS_IDLE;
            default:   next_state = CAS_IDLE;
        endcase
    end

    // Output decode from the next state, so the output flops line up with the state.
    always_comb begin
        cas_rdy_d    = (next_state == CAS_CMD);
        load_cas     = (next_state == CAS_CMD);
        data_valid_d = (next_state == CAS_BURST);
        data_rw_d    = (next_state == CAS_BURST) && req_rw;
        cas_idle_d   = (next_state == CAS_IDLE);
    end

    // Output registers. These break every input-to-output combinational path.
    // NOTE: reset returns every output to its idle value at once, without waiting for a clock edge.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            cas_rdy    <= 1'b0;
            cas_rw     <= 1'b0;
            cas_reg    <= '0;
            data_valid <= 1'b0;
            data_rw    <= 1'b0;
            cas_idle   <= 1'b1;
        end else begin
            cas_rdy    <= cas_rdy_d;
            data_valid <= data_valid_d;
            data_rw    <= data_rw_d;
            cas_idle   <= cas_idle_d;
            if (load_cas) begin
                cas_rw  <= req_rw;
                cas_reg <= req_addr;
            end
        end
    end

    // Phase counter: 1 on entry to a new state, then counts up. Held at 0 while idle.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= CNT_ONE;
        end else if (state == CAS_IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // CAS-to-CAS spacing counter: 0 in the CAS cycle, then saturates at tCCD.
    // The reset value is tCCD, so the first CAS after reset has no spacing constraint.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            ccd_cnt <= CCD_SAT;
        end else if (next_state == CAS_CMD) begin
            ccd_cnt <= '0;
        end else if (ccd_cnt != CCD_SAT) begin
            ccd_cnt <= ccd_cnt + CCD_ONE;
        end
    end

    // Capture the request type and target when the request is accepted.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            req_rw   <= 1'b0;
            req_addr <= '0;
        end else if (accept) begin
            req_rw   <= act_rw;
            req_addr <= {bg_addr, ba_addr, col_addr};
        end
    end

    // Sticky protocol error: a request while busy, or both request pulses at once.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            proto_err <= 1'b0;
        end else if (((state != CAS_IDLE) && (act_rdy || no_act_rdy)) ||
                     (act_rdy && no_act_rdy)) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_burst_cas.sv
// Testbench for burst_cas. A cycle-level model pushes the expected CAS events
// into a scoreboard queue when a request is driven. A negedge monitor pops them
// when cas_rdy fires, and also checks the data window, idle and error flags
// on every cycle. A second instance with tCCD=20 covers CAS-to-CAS spacing.

module tb_burst_cas;

    localparam int TRCD  = 14;
    localparam int TCCD  = 4;
    localparam int TCCD2 = 20;
    localparam int CL    = 14;
    localparam int CWL   = 10;
    localparam int BL    = 4;

    logic        clock_t = 1'b0;
    logic        reset_n = 1'b0;
    logic        act_rdy = 1'b0;
    logic        no_act_rdy = 1'b0;
    logic        act_rw = 1'b0;
    logic [1:0]  bg_addr = '0;
    logic [1:0]  ba_addr = '0;
    logic [9:0]  col_addr = '0;
    logic        cas_rdy, cas_rw, data_valid, data_rw, cas_idle, proto_err;
    logic [13:0] cas_reg;

    logic        act_rdy2 = 1'b0;
    logic        no_act_rdy2 = 1'b0;
    logic        cas_rdy2, cas_rw2, data_valid2, data_rw2, cas_idle2, proto_err2;
    logic [13:0] cas_reg2;

    burst_cas #(.tRCD(TRCD), .tCCD(TCCD), .CL(CL), .CWL(CWL), .BURST_CYCLES(BL),
                .CA_WIDTH(10), .BG_WIDTH(2), .BA_WIDTH(2)) dut (
        .clock_t(clock_t), .reset_n(reset_n), .act_rdy(act_rdy), .no_act_rdy(no_act_rdy),
        .act_rw(act_rw), .bg_addr(bg_addr), .ba_addr(ba_addr), .col_addr(col_addr),
        .cas_rdy(cas_rdy), .cas_rw(cas_rw), .cas_reg(cas_reg), .data_valid(data_valid),
        .data_rw(data_rw), .cas_idle(cas_idle), .proto_err(proto_err)
    );

    burst_cas #(.tRCD(TRCD), .tCCD(TCCD2), .CL(CL), .CWL(CWL), .BURST_CYCLES(BL),
                .CA_WIDTH(10), .BG_WIDTH(2), .BA_WIDTH(2)) dut_ccd (
        .clock_t(clock_t), .reset_n(reset_n), .act_rdy(act_rdy2), .no_act_rdy(no_act_rdy2),
        .act_rw(act_rw), .bg_addr(bg_addr), .ba_addr(ba_addr), .col_addr(col_addr),
        .cas_rdy(cas_rdy2), .cas_rw(cas_rw2), .cas_reg(cas_reg2), .data_valid(data_valid2),
        .data_rw(data_rw2), .cas_idle(cas_idle2), .proto_err(proto_err2)
    );

    always #5 clock_t = ~clock_t;

    int cyc = 0;
    always @(posedge clock_t) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // Scoreboard of expected CAS commands, and the model of the in-flight window.
    typedef struct {
        int          at;
        logic        rw;
        logic [13:0] addr;
    } cas_exp_t;

    cas_exp_t sb_q[$];
    int   last_cas   = -1000;
    int   busy_start = 0;
    int   busy_end   = -1;
    int   dv_start   = 0;
    int   dv_end     = -1;
    logic dv_rw      = 1'b0;
    int   proto_from = 1 << 30;
    bit   mon_en     = 1'b0;

    bit       exp_rdy;
    bit       exp_dv;
    cas_exp_t popped;

    // Per-cycle monitor for the main instance.
    always @(negedge clock_t) begin
        if (reset_n && mon_en) begin
            exp_rdy = (sb_q.size() > 0) && (sb_q[0].at == cyc);
            check("cas_rdy", cas_rdy, exp_rdy);
            if (exp_rdy) begin
                popped = sb_q.pop_front();
                if (cas_rdy) begin
                    check("cas_reg", cas_reg, popped.addr);
                    check("cas_rw", cas_rw, popped.rw);
                end
            end
            exp_dv = (cyc >= dv_start) && (cyc <= dv_end);
            check("data_valid", data_valid, exp_dv);
            if (exp_dv) check("data_rw", data_rw, dv_rw);
            check("cas_idle", cas_idle, !((cyc >= busy_start) && (cyc <= busy_end)));
            check("proto_err", proto_err, cyc >= proto_from);
        end
    end

    // Drive one legal request in the current cycle and push its expectations.
    task automatic drive_req(input logic a, input logic n, input logic rw,
                             input logic [1:0] bg, input logic [1:0] ba,
                             input logic [9:0] col, input int delay);
        int k;
        int exp_at;
        int lat;
        cas_exp_t e;
        k = cyc;
        exp_at = k + delay;
        if (!a && (last_cas + TCCD > exp_at)) exp_at = last_cas + TCCD;
        last_cas = exp_at;
        lat = rw ? CWL : CL;
        e.at = exp_at; e.rw = rw; e.addr = {bg, ba, col};
        sb_q.push_back(e);
        busy_start = k + 1;
        busy_end   = exp_at + lat + BL - 1;
        dv_start   = exp_at + lat;
        dv_end     = busy_end;
        dv_rw      = rw;
        if (a && n && proto_from > k + 1) proto_from = k + 1;
        act_rdy = a; no_act_rdy = n; act_rw = rw;
        bg_addr = bg; ba_addr = ba; col_addr = col;
        @(posedge clock_t); #1;
        act_rdy = 1'b0; no_act_rdy = 1'b0;
    endtask

    // Wait for the first idle cycle (bounded), then extra cycles, and end inside that cycle.
    task automatic wait_idle(input int extra);
        int n;
        n = 0;
        @(negedge clock_t);
        while (!cas_idle && n < 200) begin
            @(negedge clock_t);
            n++;
        end
        if (!cas_idle) check("idle_timeout", cas_idle, 1'b1);
        repeat (extra) @(negedge clock_t);
        #1;
    endtask

    // Bounded wait for a CAS pulse on the tCCD=20 instance. Returns its cycle, or -1.
    task automatic wait_cas2(output int at);
        int n;
        n = 0;
        at = -1;
        while (n < 100 && at < 0) begin
            @(negedge clock_t);
            if (cas_rdy2) at = cyc;
            n++;
        end
    endtask

    typedef struct {
        logic       act;
        logic       no_act;
        logic       rw;
        logic [1:0] bg;
        logic [1:0] ba;
        logic [9:0] col;
        int         gap;
        int         delay;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int c2;
        int k;
        int n;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 10'h03A, 2, TRCD};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 2'd2, 2'd1, 10'h155, 3, 2};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 2'd3, 2'd3, 10'h3FF, 0, 2};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 10'h000, 0, TRCD};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 10'h2AA, 1, 2};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 2'd2, 2'd3, 10'h0C5, 0, TRCD};

        // Reset, then idle for 5 cycles with the reset values checked.
        repeat (3) @(posedge clock_t);
        @(negedge clock_t);
        reset_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_t);
            check("rst_cas_idle", cas_idle, 1'b1);
            check("rst_outputs", {cas_rdy, cas_rw, data_valid, data_rw, proto_err}, 5'b0);
            check("rst_cas_reg", cas_reg, 14'h0);
        end
        #1;

        // Table-driven legal requests: ACT and row-hit paths, back-to-back at first idle.
        for (int i = 0; i < 6; i++) begin
            wait_idle(vecs[i].gap);
            drive_req(vecs[i].act, vecs[i].no_act, vecs[i].rw, vecs[i].bg,
                      vecs[i].ba, vecs[i].col, vecs[i].delay);
        end

        // act_rdy during CAS_LAT: must be ignored, and proto_err becomes sticky.
        wait_idle(1);
        drive_req(1'b1, 1'b0, 1'b1, 2'd3, 2'd0, 10'h111, TRCD);
        repeat (16) @(negedge clock_t);
        #1;
        if (proto_from > cyc + 1) proto_from = cyc + 1;
        act_rdy = 1'b1; act_rw = 1'b0; bg_addr = 2'd0; col_addr = 10'h222;
        @(posedge clock_t); #1;
        act_rdy = 1'b0;

        // tCCD=20 instance: first CAS is unconstrained, the second waits exactly 20 cycles.
        wait_idle(1);
        check("ccd_dut_idle", cas_idle2, 1'b1);
        k = cyc;
        act_rw = 1'b1; no_act_rdy2 = 1'b1;
        @(posedge clock_t); #1;
        no_act_rdy2 = 1'b0;
        wait_cas2(c1);
        check("tccd_first_cas", c1, k + 2);
        n = 0;
        @(negedge clock_t);
        while (!cas_idle2 && n < 100) begin
            @(negedge clock_t);
            n++;
        end
        #1;
        no_act_rdy2 = 1'b1;
        @(posedge clock_t); #1;
        no_act_rdy2 = 1'b0;
        wait_cas2(c2);
        check("tccd_spacing", c2, c1 + TCCD2);

        // Reset in the middle of CAS_BURST: the outputs clear at once, and a fresh ACT takes the full tRCD.
        wait_idle(1);
        drive_req(1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 10'h0F0, TRCD);
        n = 0;
        @(negedge clock_t);
        while (!data_valid && n < 100) begin
            @(negedge clock_t);
            n++;
        end
        check("burst_reached", data_valid, 1'b1);
        @(posedge clock_t); #2;
        reset_n = 1'b0;
        sb_q.delete();
        busy_end = -1; dv_end = -1; last_cas = -1000; proto_from = 1 << 30;
        #1;
        check("rst_mid_data_valid", data_valid, 1'b0);
        check("rst_mid_cas_idle", cas_idle, 1'b1);
        check("rst_mid_proto_err", proto_err, 1'b0);
        check("rst_mid_cas_reg", cas_reg, 14'h0);
        repeat (2) @(posedge clock_t);
        @(negedge clock_t);
        reset_n = 1'b1;
        @(negedge clock_t); #1;
        drive_req(1'b1, 1'b0, 1'b1, 2'd2, 2'd0, 10'h1C3, TRCD);

        // act_rdy and no_act_rdy together: the tRCD path is taken and proto_err is set.
        wait_idle(2);
        drive_req(1'b1, 1'b1, 1'b0, 2'd0, 2'd3, 10'h07E, TRCD);

        wait_idle(3);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
